// File: rtl/rst_req_gen.sv
// rst_req_gen: button/watchdog reset-request generator with stretched output.
// Optional watchdog is built when RST_REQ_WDOG_EN is defined.
module rst_req_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int STRETCH_CYCLES  = 1024,
    parameter int WDOG_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    output logic       rst_req_n,
    output logic [1:0] rst_cause,
    output logic       btn_tap,
    output logic       busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    typedef enum logic [1:0] {
        STRETCH  = 2'd0,
        WAIT_REL = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2, deb;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] str_cnt, str_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [1:0]    cause_n;
    logic          tap_n;
    logic          deb_hit, rel_event, pressed;
    logic          hold_exp, wd_exp;

    assign pressed   = ~deb;
    assign deb_hit   = (sync2 != deb) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rel_event = deb_hit && sync2;
    assign hold_exp  = (state == RUN) && pressed
                       && (hold_cnt == HW'(HOLD_CYCLES - 1));

`ifdef RST_REQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wd_cnt, wd_n;

    assign wd_exp = (state == RUN) && wdog_en && !wdog_kick
                    && (wd_cnt == WW'(WDOG_CYCLES - 1));

    // Watchdog counts only in RUN while enabled and unkicked; saturates.
    always_comb begin
        wd_n = '0;
        if (state == RUN && state_n == RUN && wdog_en && !wdog_kick
            && wd_cnt != WW'(WDOG_CYCLES))
            wd_n = wd_cnt + WW'(1);
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt <= '0;
        else     wd_cnt <= wd_n;
    end
`else
    logic unused_wdog;

    assign unused_wdog = wdog_en ^ wdog_kick ^ (WDOG_CYCLES == 0);
    assign wd_exp      = 1'b0;
`endif

    // Two-flop synchronizer and debounce filter for the raw button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_hit) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else if (deb_cnt != DW'(DEBOUNCE_CYCLES)) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Next state, stretch/hold counters, cause and tap pulse.
    always_comb begin
        state_n = state;
        str_n   = '0;
        hold_n  = '0;
        cause_n = rst_cause;
        tap_n   = 1'b0;
        unique case (state)
            STRETCH: begin
                if (str_cnt == SW'(STRETCH_CYCLES - 1))
                    state_n = WAIT_REL;
                else
                    str_n = str_cnt + SW'(1);
            end
            WAIT_REL: begin
                if (deb) state_n = RUN;
            end
            RUN: begin
                if (hold_exp) begin
                    state_n = STRETCH;
                    cause_n = 2'b01;
                end else if (wd_exp) begin
                    state_n = STRETCH;
                    cause_n = 2'b10;
                end else begin
                    if (pressed && hold_cnt != HW'(HOLD_CYCLES))
                        hold_n = hold_cnt + HW'(1);
                    tap_n = rel_event;
                end
            end
            default: state_n = STRETCH;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STRETCH;
            str_cnt   <= '0;
            hold_cnt  <= '0;
            rst_cause <= 2'b00;
            btn_tap   <= 1'b0;
            rst_req_n <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_n;
            str_cnt   <= str_n;
            hold_cnt  <= hold_n;
            rst_cause <= cause_n;
            btn_tap   <= tap_n;
            rst_req_n <= (state_n == RUN);
            busy      <= (state_n != RUN);
        end
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: expected output events are queued by the stimulus
// and matched by a monitor as the DUT produces them.
module tb_rst_req_gen;

    localparam int RISE = 0;
    localparam int FALL = 1;
    localparam int TAP  = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] cause;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       wdog_en;
    logic       wdog_kick;
    logic       rst_req_n;
    logic [1:0] rst_cause;
    logic       btn_tap;
    logic       busy;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q[$];
    logic prev_req = 1'b0;

    rst_req_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .STRETCH_CYCLES (8),
        .WDOG_CYCLES    (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .wdog_en  (wdog_en),
        .wdog_kick(wdog_kick),
        .rst_req_n(rst_req_n),
        .rst_cause(rst_cause),
        .btn_tap  (btn_tap),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input int k, input logic [1:0] cs);
        ev_t e;
        e.cyc   = c;
        e.kind  = k;
        e.cause = cs;
        q.push_back(e);
    endtask

    task automatic match(input int k);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d cause=%b",
                     k, cyc, rst_cause);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.cause !== rst_cause) begin
                errors++;
                $display("FAIL event got kind=%0d cyc=%0d cause=%b want kind=%0d cyc=%0d cause=%b",
                         k, cyc, rst_cause, e.kind, e.cyc, e.cause);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        if ({rst_req_n, busy, btn_tap, rst_cause} !== 5'b01000) begin
            errors++;
            $display("FAIL %s got req=%b busy=%b tap=%b cause=%b want 0 1 0 00",
                     tag, rst_req_n, busy, btn_tap, rst_cause);
        end
    endtask

    // Monitor: busy tracking every cycle, events on req edges and taps.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (busy !== ~rst_req_n) begin
                errors++;
                $display("FAIL busy got=%b want=%b cyc=%0d",
                         busy, ~rst_req_n, cyc);
            end
            if (rst_req_n !== prev_req)
                match(rst_req_n ? RISE : FALL);
            if (btn_tap === 1'b1)
                match(TAP);
        end
        prev_req = rst_req_n;
    end

    initial begin
        int c;
        int k;
        rst       = 1'b1;
        btn_n     = 1'b1;
        wdog_en   = 1'b0;
        wdog_kick = 1'b0;
        step(2);
        @(negedge clk);
        check_reset("por_reset");
        step(1);

        rst = 1'b0;
        expect_ev(cyc + 9, RISE, 2'b00);
        step(15);

        for (int i = 0; i < 10; i++) begin
            btn_n = 1'b0;
            step(3);
            btn_n = 1'b1;
            step(1);
        end
        step(10);

        btn_n = 1'b0;
        expect_ev(cyc + 26, FALL, 2'b01);
        step(100);
        btn_n = 1'b1;
        expect_ev(cyc + 7, RISE, 2'b01);
        step(15);

        btn_n = 1'b0;
        c = cyc;
        step(16);
        btn_n = 1'b1;
        expect_ev(c + 22, TAP, 2'b01);
        step(15);

`ifdef RST_REQ_WDOG_EN
        wdog_en   = 1'b1;
        wdog_kick = 1'b1;
        step(1);
        wdog_kick = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(48);
            wdog_kick = 1'b1;
            step(1);
            wdog_kick = 1'b0;
        end
        k = cyc;
        expect_ev(k + 50, FALL, 2'b10);
        expect_ev(k + 59, RISE, 2'b10);
        step(59);
        step(49);
        wdog_kick = 1'b1;
        step(1);
        wdog_kick = 1'b0;
        wdog_en   = 1'b0;
        step(60);
`else
        k = 0;
        wdog_en = 1'b1;
        step(120);
        wdog_en = 1'b0;
        step(5);
`endif

        btn_n = 1'b0;
        expect_ev(cyc + 26, FALL, 2'b01);
        step(28);
        btn_n = 1'b1;
        step(2);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_stretch_reset");
        step(1);
        rst = 1'b0;
        expect_ev(cyc + 9, RISE, 2'b00);
        step(20);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0 next_cyc=%0d kind=%0d",
                     q.size(), q[0].cyc, q[0].kind);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
